// File: rtl/cgra_pkg.sv
// Shared types and sizing for the CGRA kernel launcher: FSM states and the
// kernel configuration word layout.
package cgra_pkg;

  localparam int N_COL               = 4;
  localparam int KMEM_WIDTH          = 16;
  localparam int KER_CONF_N_REG_LOG2 = 4;
  localparam int IMEM_N_LINES_LOG2   = 7;
  localparam int N_SLOTS_LOG2        = 1;

  // Bit bounds of the fields inside a kernel configuration word.
  localparam int KER_N_COL_MSB    = 15;
  localparam int KER_N_COL_LSB    = 12;
  localparam int RCS_IMEM_ADD_MSB = 11;
  localparam int RCS_IMEM_ADD_LSB = 5;
  localparam int RCS_N_INSTR_MSB  = 4;
  localparam int RCS_N_INSTR_LSB  = 0;

  localparam int N_INSTR_W = RCS_N_INSTR_MSB - RCS_N_INSTR_LSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CHECK,
    RUN,
    DONE
  } launcher_state_e;

  typedef struct packed {
    logic [KER_N_COL_MSB-KER_N_COL_LSB:0]       n_col;    // one-hot column mask
    logic [RCS_IMEM_ADD_MSB-RCS_IMEM_ADD_LSB:0] imem_add; // first instruction line
    logic [RCS_N_INSTR_MSB-RCS_N_INSTR_LSB:0]   n_instr;  // instruction count - 1
  } kmem_word_t;

endpackage

// File: rtl/cgra_pc_gen.sv
// Instruction-window program counter: loads the window start, then steps
// cyclically through n_instr+1 lines, frozen while stalled.
module cgra_pc_gen
  import cgra_pkg::*;
#(
  parameter int ADD_W = IMEM_N_LINES_LOG2,
  parameter int CNT_W = N_INSTR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [ADD_W-1:0] start_addr_i,
  input  logic [CNT_W-1:0] n_instr_i,
  output logic [ADD_W-1:0] pc_o
);

  logic [CNT_W-1:0] idx_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_o  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      pc_o  <= start_addr_i;
      idx_q <= '0;
    end else if (step_i) begin
      if (idx_q == n_instr_i) begin
        pc_o  <= start_addr_i;
        idx_q <= '0;
      end else begin
        // Address wraps naturally at 2^ADD_W.
        pc_o  <= pc_o + ADD_W'(1);
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cgra_kernel_launcher.sv
// Kernel launch control: fetch config word, wait for columns, sequence the
// instruction window until EXIT. Optional run counter: CGRA_LAUNCH_PERF_CNT_EN.
module cgra_kernel_launcher
  import cgra_pkg::*;
#(
  parameter int N_COL      = cgra_pkg::N_COL,
  parameter int KMEM_WIDTH = cgra_pkg::KMEM_WIDTH,
  parameter int KER_ID_W   = KER_CONF_N_REG_LOG2,
  parameter int IMEM_ADD_W = IMEM_N_LINES_LOG2,
  parameter int SLOT_W     = N_SLOTS_LOG2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  start_ready_o,
  input  logic [KER_ID_W-1:0]   ker_id_i,
  input  logic [SLOT_W-1:0]     slot_i,
  output logic                  kmem_req_o,
  output logic [KER_ID_W-1:0]   kmem_addr_o,
  input  logic [KMEM_WIDTH-1:0] kmem_rdata_i,
  input  logic [N_COL-1:0]      col_free_i,
  output logic [N_COL-1:0]      col_en_o,
  input  logic                  stall_i,
  input  logic                  exit_i,
  output logic                  imem_rd_en_o,
  output logic [IMEM_ADD_W-1:0] imem_addr_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [SLOT_W-1:0]     done_slot_o,
  output logic [31:0]           perf_cnt_o
);

  launcher_state_e       state_q, state_d;
  logic [KER_ID_W-1:0]   id_q;
  logic [SLOT_W-1:0]     slot_q;
  kmem_word_t            cfg_q;
  logic                  err_q;
  logic [IMEM_ADD_W-1:0] pc;

  kmem_word_t            rd_word;
  logic                  accept;
  logic                  cols_ok;
  logic                  bad_kernel;

  assign rd_word    = kmem_word_t'(kmem_rdata_i);
  assign accept     = (state_q == IDLE) && start_i;
  assign cols_ok    = (N_COL'(cfg_q.n_col) & ~col_free_i) == '0;
  assign bad_kernel = (id_q == '0) || (rd_word.n_col == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      slot_q  <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q   <= ker_id_i;
        slot_q <= slot_i;
        err_q  <= 1'b0;
      end
      if (state_q == WAIT) begin
        cfg_q <= rd_word;
        err_q <= bad_kernel;
      end
    end
  end

  // NOTE: next state is defaulted to the current state before the case, so
  // every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = bad_kernel ? DONE : CHECK;
      CHECK:   if (cols_ok) state_d = RUN;
      RUN:     if (exit_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  cgra_pc_gen #(
    .ADD_W (IMEM_ADD_W),
    .CNT_W (N_INSTR_W)
  ) u_pc_gen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       ((state_q == CHECK) && cols_ok),
    .step_i       ((state_q == RUN) && !stall_i),
    .start_addr_i (IMEM_ADD_W'(cfg_q.imem_add)),
    .n_instr_i    (cfg_q.n_instr),
    .pc_o         (pc)
  );

  // Outputs decode from state so an async reset releases columns at once.
  assign start_ready_o = (state_q == IDLE);
  assign kmem_req_o    = (state_q == FETCH);
  assign kmem_addr_o   = (state_q == FETCH) ? id_q : '0;
  assign col_en_o      = (state_q == RUN) ? N_COL'(cfg_q.n_col) : '0;
  assign imem_rd_en_o  = (state_q == RUN) && !stall_i;
  assign imem_addr_o   = (state_q == RUN) ? pc : '0;
  assign done_o        = (state_q == DONE) && !err_q;
  assign err_o         = (state_q == DONE) && err_q;
  assign done_slot_o   = (state_q == DONE) ? slot_q : '0;

`ifdef CGRA_LAUNCH_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if ((state_q == RUN) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cgra_kernel_launcher.sv
// Self-checking bench for cgra_kernel_launcher: directed launches from the
// test plan plus randomized launches against a cycle-timeline reference model.
module tb_cgra_kernel_launcher;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic        start_ready_o;
  logic [3:0]  ker_id_i;
  logic [0:0]  slot_i;
  logic        kmem_req_o;
  logic [3:0]  kmem_addr_o;
  logic [15:0] kmem_rdata_i;
  logic [3:0]  col_free_i;
  logic [3:0]  col_en_o;
  logic        stall_i;
  logic        exit_i;
  logic        imem_rd_en_o;
  logic [6:0]  imem_addr_o;
  logic        done_o;
  logic        err_o;
  logic [0:0]  done_slot_o;
  logic [31:0] perf_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  cgra_kernel_launcher dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .start_ready_o (start_ready_o),
    .ker_id_i      (ker_id_i),
    .slot_i        (slot_i),
    .kmem_req_o    (kmem_req_o),
    .kmem_addr_o   (kmem_addr_o),
    .kmem_rdata_i  (kmem_rdata_i),
    .col_free_i    (col_free_i),
    .col_en_o      (col_en_o),
    .stall_i       (stall_i),
    .exit_i        (exit_i),
    .imem_rd_en_o  (imem_rd_en_o),
    .imem_addr_o   (imem_addr_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .done_slot_o   (done_slot_o),
    .perf_cnt_o    (perf_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_perf(input string tag, input int run_cycles);
`ifdef CGRA_LAUNCH_PERF_CNT_EN
    check(tag, perf_cnt_o, 32'(run_cycles));
`else
    check(tag, perf_cnt_o, 32'd0);
`endif
  endtask

  // stall_mode: 0 none, 1 random, 2 three-cycle burst starting at RUN cycle 2.
  // Each step drives inputs on the falling edge and samples 1 time unit later.
  task automatic launch(input logic [3:0] id, input logic slot, input logic [15:0] word,
                        input int wait_n, input logic [3:0] blk_free, input int n_fetch,
                        input int stall_mode, input bit exit_stall);
    logic [3:0] cols;
    logic [6:0] st;
    logic [6:0] ea;
    int         cnt;
    bit         is_err;
    bit         stall;
    int         k;
    int         cyc;
    cols   = word[15:12];
    st     = word[11:5];
    cnt    = int'(word[4:0]) + 1;
    is_err = (id == 4'd0) || (cols == 4'd0);

    // cycle 0: request accepted
    @(negedge clk);
    start_i = 1'b1; ker_id_i = id; slot_i = slot; exit_i = 1'b0; stall_i = 1'b0;
    #1 check("ready_idle", 32'(start_ready_o), 32'd1);
    // cycle 1: kernel memory read, inputs now changed to prove capture
    @(negedge clk);
    ker_id_i = ~id; slot_i = ~slot;
    #1;
    check("kmem_req", 32'(kmem_req_o), 32'd1);
    check("kmem_addr", 32'(kmem_addr_o), 32'(id));
    check("ready_busy", 32'(start_ready_o), 32'd0);
    // cycle 2: read data returned
    @(negedge clk);
    start_i = 1'b0; kmem_rdata_i = word;
    #1;
    check("kmem_req_off", 32'(kmem_req_o), 32'd0);
    check("no_fetch_wait", 32'(imem_rd_en_o), 32'd0);
    // cycle 3: DONE(err) or first CHECK cycle
    @(negedge clk);
    kmem_rdata_i = 16'($urandom);
    if (is_err) begin
      #1;
      check("err_pulse", 32'(err_o), 32'd1);
      check("err_no_done", 32'(done_o), 32'd0);
      check("err_slot", 32'(done_slot_o), 32'(slot));
      check("err_no_fetch", 32'(imem_rd_en_o), 32'd0);
      @(negedge clk);
      #1;
      check("err_once", 32'(err_o), 32'd0);
      check("err_ready", 32'(start_ready_o), 32'd1);
      return;
    end

    for (int i = 0; i < wait_n; i++) begin
      col_free_i = blk_free;
      exit_i  = 1'($urandom);
      start_i = 1'($urandom);
      #1;
      check("check_no_fetch", 32'(imem_rd_en_o), 32'd0);
      check("check_no_cols", 32'(col_en_o), 32'd0);
      check("check_not_ready", 32'(start_ready_o), 32'd0);
      @(negedge clk);
    end
    col_free_i = cols | 4'($urandom);
    exit_i = 1'b0; start_i = 1'b0;
    #1 check("free_no_fetch", 32'(imem_rd_en_o), 32'd0);

    k = 0; cyc = 0;
    while (k < n_fetch) begin
      @(negedge clk);
      case (stall_mode)
        1:       stall = ($urandom_range(0, 2) == 0);
        2:       stall = (cyc >= 2) && (cyc <= 4);
        default: stall = 1'b0;
      endcase
      stall_i = stall;
      col_free_i = 4'($urandom);
      ea = st + 7'(k % cnt);
      #1;
      check("run_addr", 32'(imem_addr_o), 32'(ea));
      check("run_rd_en", 32'(imem_rd_en_o), 32'(!stall));
      check("run_cols", 32'(col_en_o), 32'(cols));
      if (!stall) k++;
      cyc++;
      if (cyc > 2000) begin
        check("run_timeout", 32'd0, 32'd1);
        break;
      end
    end

    // exit cycle, optionally together with a stall
    @(negedge clk);
    exit_i = 1'b1; stall_i = exit_stall;
    ea = st + 7'(k % cnt);
    #1;
    check("exit_addr", 32'(imem_addr_o), 32'(ea));
    check("exit_cols", 32'(col_en_o), 32'(cols));
    cyc++;
    @(negedge clk);
    exit_i = 1'b0; stall_i = 1'b0;
    #1;
    check("done_pulse", 32'(done_o), 32'd1);
    check("done_no_err", 32'(err_o), 32'd0);
    check("done_slot", 32'(done_slot_o), 32'(slot));
    check("done_cols_off", 32'(col_en_o), 32'd0);
    check("done_no_fetch", 32'(imem_rd_en_o), 32'd0);
    check_perf("perf_done", cyc);
    @(negedge clk);
    #1;
    check("done_once", 32'(done_o), 32'd0);
    check("ready_after", 32'(start_ready_o), 32'd1);
    check_perf("perf_hold", cyc);
  endtask

  task automatic reset_mid_run();
    @(negedge clk); start_i = 1'b1; ker_id_i = 4'd2; slot_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); kmem_rdata_i = 16'h3142;
    @(negedge clk); col_free_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1 check("pre_reset_cols", 32'(col_en_o), 32'h3);
    #1 rst_ni = 1'b0;
    #1;
    check("rst_cols", 32'(col_en_o), 32'd0);
    check("rst_rd_en", 32'(imem_rd_en_o), 32'd0);
    check("rst_addr", 32'(imem_addr_o), 32'd0);
    check("rst_ready", 32'(start_ready_o), 32'd1);
    check("rst_perf", perf_cnt_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; ker_id_i = '0; slot_i = '0;
    kmem_rdata_i = '0; col_free_i = 4'hF; stall_i = 1'b0; exit_i = 1'b0;
    #12;
    check("reset_ready", 32'(start_ready_o), 32'd1);
    check("reset_kmem_req", 32'(kmem_req_o), 32'd0);
    check("reset_outs", 32'({kmem_addr_o, col_en_o, imem_rd_en_o, imem_addr_o,
                             done_o, err_o, done_slot_o}), 32'd0);
    check("reset_perf", perf_cnt_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    launch(4'd3, 1'b1, 16'h3142, 0, 4'h0, 7, 0, 1'b0);     // basic
    launch(4'd4, 1'b0, 16'h1FC3, 0, 4'h0, 4, 0, 1'b0);     // wrap
    launch(4'd3, 1'b0, 16'h3142, 4, 4'b0001, 6, 0, 1'b0);  // column wait
    launch(4'd0, 1'b1, 16'h3142, 0, 4'h0, 1, 0, 1'b0);     // id 0
    launch(4'd5, 1'b0, 16'h0142, 0, 4'h0, 1, 0, 1'b0);     // no columns
    launch(4'd6, 1'b1, 16'h3142, 0, 4'h0, 8, 2, 1'b1);     // stall burst, exit+stall
    launch(4'd7, 1'b0, 16'hF0A5, 0, 4'h0, 19, 0, 1'b0);    // 20-cycle run
    reset_mid_run();

    for (int r = 0; r < 12; r++) begin
      logic [15:0] w;
      logic [3:0]  c;
      w = 16'($urandom);
      c = w[15:12];
      launch(4'($urandom_range(0, 15)), 1'($urandom), w, $urandom_range(0, 3),
             4'($urandom) & ~c, $urandom_range(1, 40), 1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
